// File: rtl/seg595_monitor.sv
// Receive-side shadow of a two-chip 74HC595 display chain: deserializes 16-bit
// frames from the SCK/SER/RCK stream and keeps the decoded contents of eight digits.
module seg595_monitor #(
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 120000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sck_in,
    input  logic        ser_in,
    input  logic        rck_in,
    output logic [15:0] frame_data,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [39:0] digit_code,
    output logic [7:0]  digit_dot,
    output logic [7:0]  digit_seen,
    output logic        stale
);

    localparam int            IW         = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_TIMEOUT);
    localparam logic [4:0]    CNT_MAX    = 5'd31;
    localparam logic [4:0]    CNT_FULL   = 5'd16;
    localparam logic [4:0]    CODE_BLANK = 5'd16;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] ser_sync_q;
    logic [SYNC_STAGES-1:0] rck_sync_q;
    logic                   sck_prev_q;
    logic                   rck_prev_q;
    logic                   sck_rise_q;
    logic                   rck_rise_q;
    logic                   ser_q;

    logic [15:0]   shift_q, shift_d;
    logic [15:0]   frame_q, frame_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [39:0]   code_q, code_d;
    logic [7:0]    dot_q, dot_d;
    logic [7:0]    seen_q, seen_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          stale_q, stale_d;

    logic [7:0] sel_low;
    logic       sel_onehot;
    logic       accept;
    logic [4:0] seg_code;

    function automatic logic [4:0] decode_seg(input logic [6:0] lit);
        logic [4:0] code;
        case (lit)
            7'h3F:   code = 5'd0;
            7'h06:   code = 5'd1;
            7'h5B:   code = 5'd2;
            7'h4F:   code = 5'd3;
            7'h66:   code = 5'd4;
            7'h6D:   code = 5'd5;
            7'h7D:   code = 5'd6;
            7'h07:   code = 5'd7;
            7'h7F:   code = 5'd8;
            7'h6F:   code = 5'd9;
            7'h40:   code = 5'd12;
            7'h79:   code = 5'd15;
            7'h00:   code = 5'd16;
            7'h50:   code = 5'd17;
            default: code = 5'd31;
        endcase
        return code;
    endfunction

    // Synchronizers plus a registered rising-edge flag; SER is delayed alongside
    // so it lines up with the SCK edge it belongs to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_sync_q <= '0;
            ser_sync_q <= '0;
            rck_sync_q <= '0;
            sck_prev_q <= 1'b0;
            rck_prev_q <= 1'b0;
            sck_rise_q <= 1'b0;
            rck_rise_q <= 1'b0;
            ser_q      <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck_in};
            ser_sync_q <= {ser_sync_q[SYNC_STAGES-2:0], ser_in};
            rck_sync_q <= {rck_sync_q[SYNC_STAGES-2:0], rck_in};
            sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
            rck_prev_q <= rck_sync_q[SYNC_STAGES-1];
            sck_rise_q <= sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
            rck_rise_q <= rck_sync_q[SYNC_STAGES-1] & ~rck_prev_q;
            ser_q      <= ser_sync_q[SYNC_STAGES-1];
        end
    end

    assign sel_low    = ~shift_q[15:8];
    assign sel_onehot = (sel_low != 8'd0) && ((sel_low & (sel_low - 8'd1)) == 8'd0);
    assign accept     = rck_rise_q && (cnt_q >= CNT_FULL) && sel_onehot;
    assign seg_code   = decode_seg(~shift_q[6:0]);

    always_comb begin
        shift_d = shift_q;
        frame_d = frame_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        dot_d   = dot_q;
        seen_d  = seen_q;
        valid_d = accept;
        err_d   = rck_rise_q && !accept;
        idle_d  = idle_q;
        stale_d = stale_q;

        // Latch sees the pre-shift contents, matching a 595 with tied clocks.
        if (rck_rise_q) begin
            frame_d = shift_q;
        end
        if (sck_rise_q) begin
            shift_d = {shift_q[14:0], ser_q};
        end

        if (rck_rise_q) begin
            cnt_d = sck_rise_q ? 5'd1 : 5'd0;
        end else if (sck_rise_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 5'd1;
        end

        for (int i = 0; i < 8; i++) begin
            if (accept && sel_low[i]) begin
                code_d[5*i +: 5] = seg_code;
                dot_d[i]         = ~shift_q[7];
                seen_d[i]        = 1'b1;
            end
        end

        if (accept) begin
            idle_d  = '0;
            stale_d = 1'b0;
        end else begin
            if (idle_q != IDLE_MAX) begin
                idle_d = idle_q + IW'(1);
            end
            if (idle_d == IDLE_MAX) begin
                stale_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= 16'hFFFF;
            frame_q <= 16'hFFFF;
            cnt_q   <= 5'd0;
            code_q  <= {8{CODE_BLANK}};
            dot_q   <= 8'd0;
            seen_q  <= 8'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            idle_q  <= '0;
            stale_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            dot_q   <= dot_d;
            seen_q  <= seen_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            idle_q  <= idle_d;
            stale_q <= stale_d;
        end
    end

    assign frame_data  = frame_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign digit_code  = code_q;
    assign digit_dot   = dot_q;
    assign digit_seen  = seen_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_seg595_monitor.sv
// Bench for seg595_monitor: directed frames plus randomized streams scored
// against a frame-level model of the 595 chain and digit decode.
module tb_seg595_monitor;

    localparam int SS  = 2;
    localparam int IT  = 400;
    localparam int LAT = SS + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck_in = 1'b0;
    logic        ser_in = 1'b0;
    logic        rck_in = 1'b0;
    logic [15:0] frame_data;
    logic        frame_valid;
    logic        frame_err;
    logic [39:0] digit_code;
    logic [7:0]  digit_dot;
    logic [7:0]  digit_seen;
    logic        stale;

    int n_tests = 0;
    int n_fail  = 0;

    seg595_monitor #(.SYNC_STAGES(SS), .IDLE_TIMEOUT(IT)) dut (
        .clk(clk), .rst_n(rst_n), .sck_in(sck_in), .ser_in(ser_in), .rck_in(rck_in),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_err(frame_err),
        .digit_code(digit_code), .digit_dot(digit_dot), .digit_seen(digit_seen),
        .stale(stale)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: the bit stream, an unbounded edge count, and the digits.
    logic [15:0] m_shift;
    logic [15:0] m_frame;
    int          m_cnt;
    logic [4:0]  m_code [8];
    logic [7:0]  m_dot;
    logic [7:0]  m_seen;

    logic [6:0] lits [14] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                              7'h07, 7'h7F, 7'h6F, 7'h40, 7'h79, 7'h00, 7'h50};

    function automatic logic [4:0] ref_decode(input logic [6:0] lit);
        case (lit)
            7'h3F: return 5'd0;
            7'h06: return 5'd1;
            7'h5B: return 5'd2;
            7'h4F: return 5'd3;
            7'h66: return 5'd4;
            7'h6D: return 5'd5;
            7'h7D: return 5'd6;
            7'h07: return 5'd7;
            7'h7F: return 5'd8;
            7'h6F: return 5'd9;
            7'h40: return 5'd12;
            7'h79: return 5'd15;
            7'h00: return 5'd16;
            7'h50: return 5'd17;
            default: return 5'd31;
        endcase
    endfunction

    function automatic logic [39:0] m_codes();
        logic [39:0] r;
        for (int i = 0; i < 8; i++) r[5*i +: 5] = m_code[i];
        return r;
    endfunction

    task automatic model_reset();
        m_shift = 16'hFFFF;
        m_frame = 16'hFFFF;
        m_cnt   = 0;
        for (int i = 0; i < 8; i++) m_code[i] = 5'd16;
        m_dot  = 8'd0;
        m_seen = 8'd0;
    endtask

    task automatic model_sck(input logic b);
        m_shift = {m_shift[14:0], b};
        m_cnt   = m_cnt + 1;
    endtask

    task automatic model_rck(input logic with_sck, input logic b, output logic acc);
        logic [7:0] sel;
        m_frame = m_shift;
        sel     = ~m_shift[15:8];
        acc     = (m_cnt >= 16) && ($countones(sel) == 1);
        if (acc) begin
            for (int i = 0; i < 8; i++) begin
                if (sel[i]) begin
                    m_code[i] = ref_decode(~m_shift[6:0]);
                    m_dot[i]  = ~m_shift[7];
                    m_seen[i] = 1'b1;
                end
            end
        end
        m_cnt = 0;
        if (with_sck) model_sck(b);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ser_in = b;
        tick(3);
        sck_in = 1'b1;
        model_sck(b);
        tick(3);
        sck_in = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] word, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(word[i]);
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_frame"}, 64'(frame_data), 64'(m_frame));
        check_eq({tag, "_code"},  64'(digit_code), 64'(m_codes()));
        check_eq({tag, "_dot"},   64'(digit_dot),  64'(m_dot));
        check_eq({tag, "_seen"},  64'(digit_seen), 64'(m_seen));
    endtask

    // Raise RCK (optionally with SCK in the same cycle) and score the result.
    task automatic strobe(input string tag, input logic with_sck, input logic b);
        logic acc;
        int   lat;
        if (with_sck) ser_in = b;
        tick(3);
        rck_in = 1'b1;
        if (with_sck) sck_in = 1'b1;
        model_rck(with_sck, b, acc);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (frame_valid || frame_err) begin
                lat = i;
                break;
            end
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'(LAT));
        check_eq({tag, "_valid"}, 64'(frame_valid), 64'(acc));
        check_eq({tag, "_err"},   64'(frame_err),   64'(!acc));
        if (acc) check_eq({tag, "_stale_clr"}, 64'(stale), 64'(0));
        check_outputs(tag);
        @(negedge clk);
        check_eq({tag, "_pulse_end"}, 64'(frame_valid | frame_err), 64'(0));
        rck_in = 1'b0;
        sck_in = 1'b0;
        tick(3);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_valid"}, 64'(frame_valid), 64'(0));
        check_eq({tag, "_err"},   64'(frame_err),   64'(0));
        check_eq({tag, "_stale"}, 64'(stale),       64'(0));
        check_outputs(tag);
    endtask

    initial begin
        logic [15:0] word;
        logic [7:0]  sel;
        logic [7:0]  seg;
        int          nbits;
        logic        sim;

        model_reset();
        tick(3);
        check_reset_state("reset");
        check_eq("reset_frame_ffff", 64'(frame_data), 64'(16'hFFFF));
        rst_n = 1'b1;
        tick(2);

        send_bits(16'hFEB0, 16);
        strobe("feb0", 1'b0, 1'b0);
        check_eq("feb0_d1_code", 64'(digit_code[4:0]), 64'(3));
        check_eq("feb0_seen", 64'(digit_seen), 64'(8'h01));

        send_bits(16'h7F3F, 16);
        strobe("7f3f", 1'b0, 1'b0);
        check_eq("7f3f_d8_code", 64'(digit_code[39:35]), 64'(12));
        check_eq("7f3f_d8_dot", 64'(digit_dot[7]), 64'(1));

        send_bits(16'hFCB0, 16);
        strobe("fcb0_two_sel", 1'b0, 1'b0);
        check_eq("fcb0_latched", 64'(frame_data), 64'(16'hFCB0));

        send_bits(16'h02A5, 10);
        strobe("short10", 1'b0, 1'b0);
        send_bits(16'hFDC0, 16);
        strobe("fdc0", 1'b0, 1'b0);
        check_eq("fdc0_d2_code", 64'(digit_code[9:5]), 64'(0));

        tick(IT - 40);
        check_eq("stale_before", 64'(stale), 64'(0));
        tick(80);
        check_eq("stale_after", 64'(stale), 64'(1));
        send_bits(16'hF7E6, 16);
        check_eq("stale_hold", 64'(stale), 64'(1));
        strobe("stale_clear", 1'b0, 1'b0);

        // 15 edges then tied SCK/RCK: rejected, and the counter restarts at one.
        send_bits(16'h1234, 15);
        word = 16'hFBA4;
        strobe("tied_clk", 1'b1, word[15]);
        send_bits(word, 15);
        strobe("after_tied", 1'b0, 1'b0);

        send_bits(16'hBEEF, 7);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        check_reset_state("midreset");
        rst_n = 1'b1;
        tick(3);
        send_bits(16'hFE06, 5);
        strobe("post_reset_short", 1'b0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) != 0) sel = ~(8'h01 << $urandom_range(0, 7));
            else sel = 8'($urandom);
            if ($urandom_range(0, 9) < 7) seg = {1'($urandom_range(0, 1)), ~lits[$urandom_range(0, 13)]};
            else seg = 8'($urandom);
            word  = {sel, seg};
            nbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : 16;
            sim   = ($urandom_range(0, 9) == 0);
            if (nbits > 16) begin
                for (int j = 0; j < nbits - 16; j++) send_bit(1'($urandom_range(0, 1)));
                send_bits(word, 16);
            end else begin
                send_bits(word, nbits);
            end
            strobe("rand", sim, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
